// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I multi-cycle sequencer: state encoding,
// the NOP instruction loaded into IR at reset, and the default reset PC.
package rv32i_pkg;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_EXEC  = 3'd1,
        ST_MEM   = 3'd2,
        ST_WB    = 3'd3,
        ST_HALT  = 3'd4,
        ST_ERR   = 3'd5
    } seq_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // States in which a memory request is outstanding and the wait timer runs.
    function automatic logic is_wait_state(input seq_state_t s);
        return (s == ST_FETCH) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/wait_timer_rv32i.sv
// Memory wait-state timer. Down-counter loaded with TIMEOUT on clear and
// decremented on each wait cycle; expired flags the wait cycle that would
// bring the count to zero. TIMEOUT = 0 removes the counter entirely.
module wait_timer_rv32i #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic cnt_en,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT);
            localparam logic [CW-1:0] ONE      = CW'(1);

            logic [CW-1:0] remain;

            // Reload on clear, count down while the request is stalled
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    remain <= LOAD_VAL;
                end else if (clr) begin
                    remain <= LOAD_VAL;
                end else if (cnt_en && (remain != '0)) begin
                    remain <= remain - ONE;
                end
            end

            assign expired = cnt_en && (remain == ONE);
        end
    endgenerate

endmodule

// File: rtl/mc_seq_rv32i.sv
// Multi-cycle sequencer for the RV32I core. Owns PC, IR, ALU-result and
// memory-data registers and steps each instruction through FETCH/EXEC/MEM/WB
// with ready-based memory handshakes and a bounded wait timeout.
// Optional build macro: SEQ_PERF_CNT_EN enables the cycle/instret counters;
// without it both counters read 0 and no counter flops exist.
//
// state | meaning
// FETCH | imem_req high, wait for imem_ready, latch IR
// EXEC  | latch ALU result, pick MEM for loads/stores else WB
// MEM   | dmem_req high, wait for dmem_ready, latch load data
// WB    | rd_we strobe, PC <= pc_next, sample halt_req
// HALT  | idle at an instruction boundary until halt_req drops
// ERR   | memory timeout; sticky, left only through reset
module mc_seq_rv32i
    import rv32i_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC),
    parameter int               TIMEOUT  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     ir,
    input  logic [XLEN-1:0] alu_in,
    output logic [XLEN-1:0] alu_q,
    output logic [XLEN-1:0] mdr,
    input  logic [XLEN-1:0] pc_next,
    input  logic            cu_load,
    input  logic            cu_store,
    input  logic            cu_rdwrite,
    output logic            rd_we,
    input  logic            halt_req,
    output logic            halted,
    output logic            err,
    output logic [63:0]     cycle_cnt,
    output logic [63:0]     instret_cnt
);

    seq_state_t state, state_nx;
    logic       err_q;
    logic       tmr_clr, tmr_cnt, tmr_exp;

    // Wait cycles are derived from the registered state so the timer has no
    // combinational path back through the next-state logic.
    assign tmr_cnt = ((state == ST_FETCH) && !imem_ready) ||
                     ((state == ST_MEM)   && !dmem_ready);
    assign tmr_clr = (state_nx != state) && is_wait_state(state_nx);

    wait_timer_rv32i #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .cnt_en  (tmr_cnt),
        .expired (tmr_exp)
    );

    // State register and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FETCH;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state_nx == ST_ERR) begin
                err_q <= 1'b1;
            end
        end
    end

    // Next-state and request/strobe decode from the registered state
    always_comb begin
        state_nx = state;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rd_we    = 1'b0;
        case (state)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    state_nx = ST_EXEC;
                end else if (tmr_exp) begin
                    state_nx = ST_ERR;
                end
            end
            ST_EXEC: begin
                state_nx = (cu_load || cu_store) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = cu_store;
                if (dmem_ready) begin
                    state_nx = ST_WB;
                end else if (tmr_exp) begin
                    state_nx = ST_ERR;
                end
            end
            ST_WB: begin
                rd_we = cu_rdwrite;
                // Timeouts jump straight to ERR, so err_q only guards WB
                // against any error recorded while the instruction was in flight.
                if (err_q) begin
                    state_nx = ST_ERR;
                end else if (halt_req) begin
                    state_nx = ST_HALT;
                end else begin
                    state_nx = ST_FETCH;
                end
            end
            ST_HALT: begin
                if (!halt_req) begin
                    state_nx = ST_FETCH;
                end
            end
            ST_ERR: begin
                state_nx = ST_ERR;
            end
            default: begin
                state_nx = ST_FETCH;
            end
        endcase
    end

    // Architectural registers, each written in exactly one state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            ir    <= NOP_INSN;
            alu_q <= '0;
            mdr   <= '0;
        end else begin
            if ((state == ST_FETCH) && imem_ready) begin
                ir <= imem_rdata;
            end
            if (state == ST_EXEC) begin
                alu_q <= alu_in;
            end
            if ((state == ST_MEM) && dmem_ready && cu_load) begin
                mdr <= dmem_rdata;
            end
            if (state == ST_WB) begin
                pc <= pc_next;
            end
        end
    end

    assign imem_addr = pc;
    assign halted    = (state == ST_HALT);
    assign err       = err_q;

`ifdef SEQ_PERF_CNT_EN
    // Free-running cycle counter and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= 64'd0;
            instret_cnt <= 64'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (state == ST_WB) begin
                instret_cnt <= instret_cnt + 64'd1;
            end
        end
    end
`else
    assign cycle_cnt   = 64'd0;
    assign instret_cnt = 64'd0;
`endif

endmodule

// File: tb/tb_mc_seq_rv32i.sv
// Self-checking bench for mc_seq_rv32i: directed vector table, random
// instruction stream against a transaction-level model, and hand-written
// sequences for halt, reset during MEM and fetch/data timeouts.
module tb_mc_seq_rv32i;

    localparam int          TMO    = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        dmem_req, dmem_we;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic [31:0] pc, ir, alu_in, alu_q, mdr, pc_next;
    logic        cu_load, cu_store, cu_rdwrite;
    logic        rd_we;
    logic        halt_req = 1'b0;
    logic        halted, err;
    logic [63:0] cycle_cnt, instret_cnt;

    int     checks = 0;
    int     errors = 0;
    logic [31:0] m_pc, m_alu, m_mdr;
    longint m_cyc, m_inst;

    always #5 clk = ~clk;

    // Environment: decode, ALU and brancher stand-ins driven from IR/PC
    assign cu_load    = (ir[6:0] == 7'h03);
    assign cu_store   = (ir[6:0] == 7'h23);
    assign cu_rdwrite = !cu_store && (ir[6:0] != 7'h63);
    assign alu_in     = pc + ir;
    assign pc_next    = (ir[6:0] == 7'h63) ? pc + {23'd0, ir[31:25], 2'b00} : pc + 32'd4;

    mc_seq_rv32i #(
        .XLEN     (32),
        .RESET_PC (RST_PC),
        .TIMEOUT  (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ready  (dmem_ready),
        .dmem_rdata  (dmem_rdata),
        .pc          (pc),
        .ir          (ir),
        .alu_in      (alu_in),
        .alu_q       (alu_q),
        .mdr         (mdr),
        .pc_next     (pc_next),
        .cu_load     (cu_load),
        .cu_store    (cu_store),
        .cu_rdwrite  (cu_rdwrite),
        .rd_we       (rd_we),
        .halt_req    (halt_req),
        .halted      (halted),
        .err         (err),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    typedef struct {
        logic [31:0] insn;
        int          fw;
        int          mw;
        logic [31:0] ld;
        int          exp_lat;
        int          exp_rdwe;
        int          exp_dreq;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        m_cyc++;
    endtask

    function automatic logic [63:0] perf(input longint v);
`ifdef SEQ_PERF_CNT_EN
        return 64'(v);
`else
        return 64'd0 & 64'(v);
`endif
    endfunction

    function automatic logic [31:0] mk_insn(input int kind, input logic [31:0] r);
        logic [6:0] op;
        case (kind)
            0:       op = 7'h13;
            1:       op = 7'h03;
            2:       op = 7'h23;
            default: op = 7'h63;
        endcase
        return {r[31:7], op};
    endfunction

    function automatic logic [31:0] model_next_pc(input logic [31:0] p, input logic [31:0] insn);
        if (insn[6:0] == 7'h63) return p + 32'(insn[31:25]) * 32'd4;
        return p + 32'd4;
    endfunction

    task automatic model_reset();
        m_pc  = RST_PC;
        m_alu = 32'h0;
        m_mdr = 32'h0;
        m_cyc = 0;
        m_inst = 0;
    endtask

    // Acts as both memories for one instruction; entered and left at a
    // falling edge with the DUT in FETCH.
    task automatic run_instr(input vec_t v, input string tag);
        int fwc = 0, mwc = 0, lat = 0, rdwe_n = 0, dreq_n = 0, dwe_n = 0, addr_bad = 0;
        bit left = 0, done = 0;
        bit is_ld, is_st;
        is_ld = (v.insn[6:0] == 7'h03);
        is_st = (v.insn[6:0] == 7'h23);
        for (int k = 0; k < 40; k++) begin
            if (imem_req && left) begin
                done = 1;
                break;
            end
            if (imem_req) begin
                if (imem_addr !== m_pc) addr_bad++;
                imem_ready = (fwc == v.fw);
                imem_rdata = (fwc == v.fw) ? v.insn : JUNK;
                fwc++;
            end else begin
                left = 1;
                imem_ready = 1'($urandom_range(0, 1));
                imem_rdata = JUNK;
            end
            if (dmem_req) begin
                dreq_n++;
                if (dmem_we) dwe_n++;
                dmem_ready = (mwc == v.mw);
                dmem_rdata = (mwc == v.mw) ? v.ld : JUNK;
                mwc++;
            end else begin
                dmem_ready = 1'($urandom_range(0, 1));
                dmem_rdata = JUNK;
            end
            if (rd_we) rdwe_n++;
            lat++;
            step();
        end
        chk({tag, " completed"}, 64'(done), 64'd1);
        chk({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
        chk({tag, " rd_we pulses"}, 64'(rdwe_n), 64'(v.exp_rdwe));
        chk({tag, " dmem_req cycles"}, 64'(dreq_n), 64'(v.exp_dreq));
        chk({tag, " dmem_we cycles"}, 64'(dwe_n), is_st ? 64'(v.exp_dreq) : 64'd0);
        chk({tag, " imem_addr"}, 64'(addr_bad), 64'd0);
        m_alu = m_pc + v.insn;
        m_pc  = model_next_pc(m_pc, v.insn);
        if (is_ld) m_mdr = v.ld;
        m_inst++;
        chk({tag, " pc"}, 64'(pc), 64'(m_pc));
        chk({tag, " ir"}, 64'(ir), 64'(v.insn));
        chk({tag, " alu_q"}, 64'(alu_q), 64'(m_alu));
        chk({tag, " mdr"}, 64'(mdr), 64'(m_mdr));
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, " cycle_cnt"}, cycle_cnt, perf(m_cyc));
        chk({tag, " instret_cnt"}, instret_cnt, perf(m_inst));
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[6];
        vec_t rv;
        int kind;

        // ADDI x1,x0,5 / LW x2,8(x0) / SW x2,12(x0) / BEQ with +128 / ADDI / LW
        vt[0] = '{32'h0050_0093, 0, 0, 32'h0,         3, 1, 0};
        vt[1] = '{32'h0080_2103, 0, 2, 32'h1234_5678, 6, 1, 3};
        vt[2] = '{32'h0020_2623, 0, 0, 32'h0,         4, 0, 1};
        vt[3] = '{32'h4000_0063, 1, 0, 32'h0,         4, 0, 0};
        vt[4] = '{32'h0FF0_0093, 3, 0, 32'h0,         6, 1, 0};
        vt[5] = '{32'h0040_2183, 1, 1, 32'hCAFE_F00D, 6, 1, 2};

        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        chk("reset pc", 64'(pc), 64'(RST_PC));
        chk("reset ir", 64'(ir), 64'(NOP));
        chk("reset alu_q", 64'(alu_q), 64'd0);
        chk("reset mdr", 64'(mdr), 64'd0);
        chk("reset rd_we", 64'(rd_we), 64'd0);
        chk("reset dmem_req", 64'(dmem_req), 64'd0);
        chk("reset halted", 64'(halted), 64'd0);
        chk("reset err", 64'(err), 64'd0);
        chk("first cycle imem_req", 64'(imem_req), 64'd1);
        chk_counters("reset");

        for (int i = 0; i < 6; i++) begin
            run_instr(vt[i], $sformatf("vec%0d", i));
        end
        chk_counters("after vectors");

        for (int i = 0; i < 150; i++) begin
            kind    = $urandom_range(0, 3);
            rv.insn = mk_insn(kind, $urandom);
            rv.fw   = $urandom_range(0, TMO - 1);
            rv.mw   = $urandom_range(0, TMO - 1);
            rv.ld   = $urandom;
            rv.exp_lat  = 3 + rv.fw + ((kind == 1 || kind == 2) ? 1 + rv.mw : 0);
            rv.exp_rdwe = (kind == 0 || kind == 1) ? 1 : 0;
            rv.exp_dreq = (kind == 1 || kind == 2) ? 1 + rv.mw : 0;
            run_instr(rv, $sformatf("rnd%0d", i));
        end
        chk_counters("after random");

        // Halt raised during EXEC of an ADDI
        chk("halt fetch imem_req", 64'(imem_req), 64'd1);
        imem_ready = 1'b1; imem_rdata = 32'h0050_0093; dmem_ready = 1'b0;
        step();
        imem_ready = 1'b0; imem_rdata = JUNK; halt_req = 1'b1;
        step();
        chk("halt wb rd_we", 64'(rd_we), 64'd1);
        chk("halt wb halted", 64'(halted), 64'd0);
        step();
        m_alu = m_pc + 32'h0050_0093;
        m_pc  = m_pc + 32'd4;
        m_inst++;
        for (int k = 0; k < 3; k++) begin
            chk("halt halted", 64'(halted), 64'd1);
            chk("halt imem_req", 64'(imem_req), 64'd0);
            imem_ready = 1'b1;
            step();
        end
        chk("halt pc", 64'(pc), 64'(m_pc));
        chk("halt alu_q", 64'(alu_q), 64'(m_alu));
        halt_req = 1'b0; imem_ready = 1'b0;
        step();
        chk("unhalt imem_req", 64'(imem_req), 64'd1);
        chk("unhalt halted", 64'(halted), 64'd0);
        chk("unhalt imem_addr", 64'(imem_addr), 64'(m_pc));
        chk_counters("after halt");

        // Spurious dmem_ready while waiting in FETCH
        dmem_ready = 1'b1; dmem_rdata = JUNK; imem_ready = 1'b0;
        step();
        chk("spurious mdr", 64'(mdr), 64'(m_mdr));
        chk("spurious imem_req", 64'(imem_req), 64'd1);
        chk("spurious pc", 64'(pc), 64'(m_pc));
        dmem_ready = 1'b0;

        // Reset asserted while a load waits in MEM
        imem_ready = 1'b1; imem_rdata = 32'h0080_2103;
        step();
        imem_ready = 1'b0;
        step();
        chk("mid-mem dmem_req", 64'(dmem_req), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async drop dmem_req", 64'(dmem_req), 64'd0);
        release_reset();
        chk("post-reset pc", 64'(pc), 64'(RST_PC));
        chk("post-reset ir", 64'(ir), 64'(NOP));
        chk("post-reset mdr", 64'(mdr), 64'd0);
        chk("post-reset imem_req", 64'(imem_req), 64'd1);
        chk_counters("post-reset");
        for (int i = 0; i < 4; i++) begin
            kind    = $urandom_range(0, 3);
            rv.insn = mk_insn(kind, $urandom);
            rv.fw = 0; rv.mw = 1; rv.ld = $urandom;
            rv.exp_lat  = 3 + ((kind == 1 || kind == 2) ? 2 : 0);
            rv.exp_rdwe = (kind == 0 || kind == 1) ? 1 : 0;
            rv.exp_dreq = (kind == 1 || kind == 2) ? 2 : 0;
            run_instr(rv, $sformatf("recov%0d", i));
        end

        // Fetch timeout: imem_ready held low
        imem_ready = 1'b0; dmem_ready = 1'b0;
        for (int k = 0; k < TMO; k++) begin
            chk("tmo fetch imem_req", 64'(imem_req), 64'd1);
            chk("tmo fetch err", 64'(err), 64'd0);
            step();
        end
        chk("tmo fetch err set", 64'(err), 64'd1);
        chk("tmo fetch imem_req low", 64'(imem_req), 64'd0);
        chk("tmo fetch pc", 64'(pc), 64'(m_pc));
        imem_ready = 1'b1; dmem_ready = 1'b1;
        repeat (3) step();
        chk("tmo sticky err", 64'(err), 64'd1);
        chk("tmo sticky imem_req", 64'(imem_req), 64'd0);
        chk("tmo sticky dmem_req", 64'(dmem_req), 64'd0);
        chk_counters("in ERR");
        rst_n = 1'b0;
        #1;
        chk("reset clears err", 64'(err), 64'd0);
        imem_ready = 1'b0; dmem_ready = 1'b0;
        release_reset();

        // Data timeout: store whose dmem_ready never arrives
        imem_ready = 1'b1; imem_rdata = 32'h0020_2623;
        step();
        imem_ready = 1'b0;
        step();
        for (int k = 0; k < TMO; k++) begin
            chk("tmo mem dmem_req", 64'(dmem_req), 64'd1);
            chk("tmo mem dmem_we", 64'(dmem_we), 64'd1);
            step();
        end
        chk("tmo mem err", 64'(err), 64'd1);
        chk("tmo mem dmem_req low", 64'(dmem_req), 64'd0);
        chk("tmo mem pc", 64'(pc), 64'(m_pc));
        chk_counters("mem ERR");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_seq_rv32i.md
# mc_seq_rv32i

Multi-cycle sequencer for the RV32I core: owns the PC, instruction register (IR), ALU-result register and memory-data register, and steps each instruction through FETCH/EXEC/MEM/WB with ready-based memory handshakes. It replaces the one-instruction-per-clock control flow of the single-cycle top level. Memories may now insert wait states, and a bounded timeout raises a sticky error. The existing combinational decode, ALU, brancher and load-select blocks sit around it unchanged.

## Interface
- XLEN, 32, datapath width
- RESET_PC, 32'h0000_0000, PC value after reset
- TIMEOUT, 16, max wait cycles per memory request; 0 disables timeout
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  XLEN  fetch address (= pc)
- imem_ready  in  1  fetch data valid this cycle
- imem_rdata  in  32  fetched instruction
- dmem_req  out  1  data access request
- dmem_we  out  1  store (1) / load (0)
- dmem_ready  in  1  data access complete
- dmem_rdata  in  XLEN  raw load data
- pc  out  XLEN  current PC register
- ir  out  32  instruction register, feeds decode
- alu_in  in  XLEN  combinational ALU result
- alu_q  out  XLEN  ALU result latched in EXEC; drives dmem address and rd path
- mdr  out  XLEN  load data latched in MEM
- pc_next  in  XLEN  next PC from brancher/jump mux
- cu_load, cu_store, cu_rdwrite  in  1 each  decoded from ir
- rd_we  out  1  register-file write strobe, one cycle in WB
- halt_req  in  1  stop at next instruction boundary
- halted  out  1  in HALT state
- err  out  1  sticky timeout error
- cycle_cnt, instret_cnt  out  64 each  performance counters

## Operation
- States: FETCH, EXEC, MEM, WB, HALT, ERR.
- FETCH: imem_req=1. On imem_ready, IR <= imem_rdata, then go to EXEC.
- EXEC: alu_q <= alu_in. If cu_load|cu_store go to MEM, else go to WB.
- MEM: dmem_req=1, dmem_we=cu_store. On dmem_ready: load sets mdr <= dmem_rdata; go to WB.
- WB: rd_we=cu_rdwrite and pc <= pc_next. Then go to ERR if an error is pending, else HALT if halt_req, else FETCH.
- HALT: all requests low. When halt_req=0, go to FETCH.
- ERR: all requests low, err=1. Exit only by reset.
- Timeout: the wait counter clears on entering FETCH/MEM and increments each cycle with req=1 and ready=0. On reaching TIMEOUT, go to ERR and leave pc unchanged.
- ready while the matching req is low is ignored.
- Reset mid-request: the request drops immediately and the FSM returns to FETCH at RESET_PC.

## Timing
- Reset values: pc=RESET_PC, ir=32'h0000_0013 (NOP), alu_q=0, mdr=0, state FETCH, err=0, halted=0, counters 0, rd_we=0, dmem_req=0.
- imem_req=1 in the first cycle after reset release, because state is already FETCH.
- req, addr and we are decoded from the registered state and stay stable until ready is sampled at a rising edge.
- Zero-wait latency: ALU/branch/jump instructions take 3 cycles; loads and stores take 4. Each wait state adds one cycle.
- halt_req is sampled only in WB. halted asserts the cycle after WB.

## Configuration
- SEQ_PERF_CNT_EN defined: cycle_cnt increments every cycle out of reset, including HALT/ERR. instret_cnt increments on every WB.
- SEQ_PERF_CNT_EN undefined: both counters are tied to 0 and no counter flops are present.

## Structure
- Shared package rv32i_pkg holds the state encoding, the NOP constant 32'h0000_0013 and the default RESET_PC.
- One sub-module, wait_timer_rv32i, holds the parametrised timeout counter (clear, count, expired).

## Test plan
- Zero-wait ADDI x1,x0,5 at RESET_PC=0: imem_req in cycle 1, rd_we pulse in cycle 3, pc=4 in cycle 4.
- LW with dmem_ready delayed 2 cycles: dmem_req high for 3 cycles, mdr=dmem_rdata, total latency 6 cycles, instret_cnt+1.
- TIMEOUT=4 and imem_ready held 0: err=1 after 4 wait cycles, imem_req=0, pc unchanged; stays in ERR until rst_n low.
- halt_req raised during EXEC: instruction completes, halted=1 after WB, no imem_req. Releasing halt_req gives imem_req the next cycle at pc_next.
- Spurious dmem_ready during FETCH: no state or mdr change.
- rst_n low mid-MEM: dmem_req drops asynchronously, and pc=RESET_PC and ir=NOP on release.
